score_fetch_controller: RTL and testbench

SCORE_FETCH_CONTROLLER -- requirements
Module: score_fetch_controller

---
 rtl/score_fetch_controller.sv | 125 ++++++++++++
 tb/tb_score_fetch_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/score_fetch_controller.sv
// Sequences the three neighbour reads (diag, up, left) for every cell of an
// (N+1)x(N+1) score matrix, then hands the registered neighbours to the scoring datapath.
module score_fetch_controller #(
    parameter int N      = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cell_ack,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              en_read,
    output logic [1:0]        count,
    output logic              signal,
    output logic              cell_valid,
    output logic [ADDR_W-1:0] cell_i,
    output logic [ADDR_W-1:0] cell_j,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(N + 1);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE, RD_DIAG, RD_UP, RD_LEFT, CAP_LEFT, PRESENT, WAIT_ACK, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] i_q, j_q;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] prev_base;

    // row_base always equals i*(N+1); the row above is one step back.
    assign prev_base = row_base - ROW_STEP;
    assign wr_addr   = row_base + j_q;
    assign cell_i    = i_q;
    assign cell_j    = j_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            row_base <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                i_q      <= ONE;
                j_q      <= ONE;
                row_base <= ROW_STEP;
            end else if (state == WAIT_ACK && cell_ack) begin
                if (j_q < LAST) begin
                    j_q <= j_q + ONE;
                end else if (i_q < LAST) begin
                    i_q      <= i_q + ONE;
                    j_q      <= ONE;
                    row_base <= row_base + ROW_STEP;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ram_rd_en  = 1'b0;
        ram_addr   = '0;
        en_read    = 1'b0;
        count      = 2'd0;
        signal     = 1'b0;
        cell_valid = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RD_DIAG;
            end
            RD_DIAG: begin
                ram_rd_en = 1'b1;
                ram_addr  = prev_base + j_q - ONE;
                state_nxt = RD_UP;
            end
            // en_read trails each read by one cycle to line up with RAM data.
            RD_UP: begin
                ram_rd_en = 1'b1;
                ram_addr  = prev_base + j_q;
                en_read   = 1'b1;
                count     = 2'd0;
                state_nxt = RD_LEFT;
            end
            RD_LEFT: begin
                ram_rd_en = 1'b1;
                ram_addr  = row_base + j_q - ONE;
                en_read   = 1'b1;
                count     = 2'd1;
                state_nxt = CAP_LEFT;
            end
            CAP_LEFT: begin
                en_read   = 1'b1;
                count     = 2'd2;
                state_nxt = PRESENT;
            end
            PRESENT: begin
                signal    = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                cell_valid = 1'b1;
                if (cell_ack) begin
                    if (j_q < LAST || i_q < LAST) state_nxt = RD_DIAG;
                    else                          state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_score_fetch_controller.sv
// Randomized bench for score_fetch_controller: an N=2 and an N=1 instance are
// compared cycle by cycle against a matrix-walk reference model.
module tb_score_fetch_controller;

    localparam int NA = 2, AWA = 4;
    localparam int NB = 1, AWB = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cell_ack = 1'b0;
    int   sel = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    logic start_a, start_b, ack_a, ack_b;
    assign start_a = start & (sel == 0);
    assign ack_a   = cell_ack & (sel == 0);
    assign start_b = start & (sel == 1);
    assign ack_b   = cell_ack & (sel == 1);

    logic           rd_a, er_a, sg_a, cv_a, bs_a, dn_a;
    logic [1:0]     cnt_a;
    logic [AWA-1:0] addr_a, ci_a, cj_a, wr_a;
    logic           rd_b, er_b, sg_b, cv_b, bs_b, dn_b;
    logic [1:0]     cnt_b;
    logic [AWB-1:0] addr_b, ci_b, cj_b, wr_b;

    score_fetch_controller #(.N(NA), .ADDR_W(AWA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cell_ack(ack_a),
        .ram_rd_en(rd_a), .ram_addr(addr_a), .en_read(er_a), .count(cnt_a),
        .signal(sg_a), .cell_valid(cv_a), .cell_i(ci_a), .cell_j(cj_a),
        .wr_addr(wr_a), .busy(bs_a), .done(dn_a)
    );

    score_fetch_controller #(.N(NB), .ADDR_W(AWB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cell_ack(ack_b),
        .ram_rd_en(rd_b), .ram_addr(addr_b), .en_read(er_b), .count(cnt_b),
        .signal(sg_b), .cell_valid(cv_b), .cell_i(ci_b), .cell_j(cj_b),
        .wr_addr(wr_b), .busy(bs_b), .done(dn_b)
    );

    logic [39:0] obs_a, obs_b, obs;
    assign obs_a = {rd_a, 8'(addr_a), er_a, cnt_a, sg_a, cv_a, dn_a, bs_a,
                    8'(ci_a), 8'(cj_a), 8'(wr_a)};
    assign obs_b = {rd_b, 8'(addr_b), er_b, cnt_b, sg_b, cv_b, dn_b, bs_b,
                    8'(ci_b), 8'(cj_b), 8'(wr_b)};
    assign obs   = (sel == 0) ? obs_a : obs_b;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ph 0..5 = cycle within a cell, 6 = done cycle, 7 = idle
    function automatic logic [39:0] exp_vec(input int n, input int ph, input int ci, input int cj);
        int   w;
        int   addr;
        int   cnt;
        logic rd, er, sg, cv, dn, bs;
        w = n + 1; addr = 0; cnt = 0;
        rd = 1'b0; er = 1'b0; sg = 1'b0; cv = 1'b0; dn = 1'b0; bs = 1'b1;
        case (ph)
            0: begin rd = 1'b1; addr = (ci - 1) * w + cj - 1; end
            1: begin rd = 1'b1; addr = (ci - 1) * w + cj; er = 1'b1; cnt = 0; end
            2: begin rd = 1'b1; addr = ci * w + cj - 1; er = 1'b1; cnt = 1; end
            3: begin er = 1'b1; cnt = 2; end
            4: sg = 1'b1;
            5: cv = 1'b1;
            6: dn = 1'b1;
            default: bs = 1'b0;
        endcase
        return {rd, 8'(addr), er, 2'(cnt), sg, cv, dn, bs, 8'(ci), 8'(cj), 8'(ci * w + cj)};
    endfunction

    task automatic run_matrix(input int s, input int n, input int long_idx, input int abort_idx);
        int idx;
        int d;
        idx = 0;
        sel = s;
        cell_ack = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int ci = 1; ci <= n; ci++) begin
            for (int cj = 1; cj <= n; cj++) begin
                for (int ph = 0; ph < 5; ph++) begin
                    check($sformatf("n%0d_c%0d%0d_ph%0d", n, ci, cj, ph), obs, exp_vec(n, ph, ci, cj));
                    if (idx == abort_idx && ph == 4) begin
                        #2 rst = 1'b0;
                        #1 check("async_rst", obs, exp_vec(n, 7, 0, 0));
                        @(negedge clk);
                        check("rst_held", obs, exp_vec(n, 7, 0, 0));
                        rst = 1'b1; start = 1'b0; cell_ack = 1'b0;
                        repeat (3) begin
                            @(negedge clk);
                            check("post_rst_idle", obs, exp_vec(n, 7, 0, 0));
                        end
                        return;
                    end
                    start    = 1'($urandom_range(0, 1));
                    cell_ack = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                d = (idx == long_idx) ? 20 : int'($urandom_range(0, 4));
                for (int k = 0; k <= d; k++) begin
                    check($sformatf("n%0d_c%0d%0d_wait%0d", n, ci, cj, k), obs, exp_vec(n, 5, ci, cj));
                    start    = 1'($urandom_range(0, 1));
                    cell_ack = (k == d);
                    @(negedge clk);
                end
                idx++;
            end
        end
        check($sformatf("n%0d_done", n), obs, exp_vec(n, 6, n, n));
        start = 1'b0;
        cell_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check($sformatf("n%0d_idle_after", n), obs, exp_vec(n, 7, n, n));
        cell_ack = 1'b0;
        @(negedge clk);
        check($sformatf("n%0d_idle_hold", n), obs, exp_vec(n, 7, n, n));
    endtask

    initial begin
        #12;
        check("reset_a", obs_a, exp_vec(NA, 7, 0, 0));
        check("reset_b", obs_b, exp_vec(NB, 7, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_no_start", obs_a, exp_vec(NA, 7, 0, 0));
        run_matrix(0, NA, -1, -1);
        run_matrix(0, NA, 1, -1);
        run_matrix(0, NA, -1, 2);
        run_matrix(0, NA, 3, -1);
        run_matrix(1, NB, -1, -1);
        run_matrix(1, NB, 0, -1);
        run_matrix(0, NA, -1, -1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
